// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
// State encoding and port IDs are shared by the top and the round-robin picker.
package dmem_arbiter_pkg;

    localparam int unsigned DefaultDsize = 16;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StResp = 2'd2
    } state_e;

    localparam logic PortC = 1'b0;
    localparam logic PortD = 1'b1;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Combinational two-way round-robin picker.
// On a tie, the port that did not hold the last grant wins.
module dmem_arbiter_rr_arb2
    import dmem_arbiter_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic       valid_o,
    output logic       winner_o
);

    always_comb begin
        valid_o  = |req_i;
        winner_o = last_i;
        case (req_i)
            2'b01:   winner_o = PortC;
            2'b10:   winner_o = PortD;
            2'b11:   winner_o = ~last_i;
            default: winner_o = last_i;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data memory between the CPU (port C) and a debug/loader engine (port D),
// one transaction at a time, with a sticky timeout watchdog on the memory handshake.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned DSIZE   = DefaultDsize,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             c_req,
    input  logic             c_we,
    input  logic [DSIZE-1:0] c_addr,
    input  logic [DSIZE-1:0] c_wdata,
    output logic [DSIZE-1:0] c_rdata,
    output logic             c_ack,
    output logic             c_stall,

    input  logic             d_req,
    input  logic             d_we,
    input  logic [DSIZE-1:0] d_addr,
    input  logic [DSIZE-1:0] d_wdata,
    output logic [DSIZE-1:0] d_rdata,
    output logic             d_ack,

    output logic             m_req,
    output logic             m_we,
    output logic [DSIZE-1:0] m_addr,
    output logic [DSIZE-1:0] m_wdata,
    input  logic [DSIZE-1:0] m_rdata,
    input  logic             m_ack,

    output logic             owner,
    output logic             err
);

    state_e           state_q, state_d;
    logic             owner_q, owner_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             m_we_q, m_we_d;
    logic [DSIZE-1:0] m_addr_q, m_addr_d;
    logic [DSIZE-1:0] m_wdata_q, m_wdata_d;
    logic [DSIZE-1:0] c_rdata_q, c_rdata_d;
    logic [DSIZE-1:0] d_rdata_q, d_rdata_d;

    logic grant_valid;
    logic grant_winner;

    dmem_arbiter_rr_arb2 u_rr_arb2 (
        .req_i    ({d_req, c_req}),
        .last_i   (owner_q),
        .valid_o  (grant_valid),
        .winner_o (grant_winner)
    );

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        m_we_d    = m_we_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        c_rdata_d = c_rdata_q;
        d_rdata_d = d_rdata_q;

        case (state_q)
            StIdle: begin
                if (grant_valid) begin
                    m_we_d    = (grant_winner == PortD) ? d_we    : c_we;
                    m_addr_d  = (grant_winner == PortD) ? d_addr  : c_addr;
                    m_wdata_d = (grant_winner == PortD) ? d_wdata : c_wdata;
                    owner_d   = grant_winner;
                    cnt_d     = 8'd0;
                    state_d   = StBusy;
                end
            end
            StBusy: begin
                if (m_ack) begin
                    if (!m_we_q) begin
                        if (owner_q == PortD) d_rdata_d = m_rdata;
                        else                  c_rdata_d = m_rdata;
                    end
                    state_d = StResp;
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    // Abort: complete the access to the requester with zero read data.
                    err_d = 1'b1;
                    if (!m_we_q) begin
                        if (owner_q == PortD) d_rdata_d = '0;
                        else                  c_rdata_d = '0;
                    end
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            owner_q   <= PortD;
            cnt_q     <= 8'd0;
            err_q     <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            c_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            m_we_q    <= m_we_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            c_rdata_q <= c_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    assign m_req   = (state_q == StBusy);
    assign m_we    = m_we_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign c_ack   = (state_q == StResp) && (owner_q == PortC);
    assign d_ack   = (state_q == StResp) && (owner_q == PortD);
    assign c_rdata = c_rdata_q;
    assign d_rdata = d_rdata_q;
    assign c_stall = c_req & ~c_ack;
    assign owner   = owner_q;
    assign err     = err_q;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data memory between two requesters: the CPU data-memory stage (port C) and a debug/loader engine (port D).
- Port D preloads and inspects data memory while the program runs.
- Grants the memory one transaction at a time, round-robin when both ports request, and freezes the CPU pipeline through c_stall while a CPU access is pending.
- A timeout watchdog flags a memory that never acknowledges.

Parameters:
- DSIZE, 16, data and address width (matches `DSIZE)
- TIMEOUT, 15, maximum BUSY cycles without m_ack before abort; legal 1..255

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- c_req  in  1  CPU request; held high until c_ack
- c_we  in  1  CPU write (1) / read (0)
- c_addr  in  DSIZE  CPU address
- c_wdata  in  DSIZE  CPU write data
- c_rdata  out  DSIZE  CPU read data; valid while c_ack
- c_ack  out  1  one-cycle completion pulse to CPU
- c_stall  out  1  CPU pipeline freeze
- d_req  in  1  debug request
- d_we  in  1  debug write/read
- d_addr  in  DSIZE  debug address
- d_wdata  in  DSIZE  debug write data
- d_rdata  out  DSIZE  debug read data; valid while d_ack
- d_ack  out  1  one-cycle completion pulse to debug port
- m_req  out  1  memory transaction request
- m_we  out  1  memory write enable
- m_addr  out  DSIZE  memory address
- m_wdata  out  DSIZE  memory write data
- m_rdata  in  DSIZE  memory read data; valid with m_ack
- m_ack  in  1  memory completion
- owner  out  1  port of the current or last grant (0 = C, 1 = D)
- err  out  1  sticky timeout flag

Behaviour:
- Reset (rst high at a clock edge) forces:
  - state IDLE
  - all outputs 0: m_req, m_we, m_addr, m_wdata, c_ack, d_ack, c_rdata, d_rdata, err
  - owner = 1, so the CPU wins the first tie
  - timeout counter 0
- Reset mid-transaction abandons it immediately: m_req drops the next cycle and no ack is issued. The memory must tolerate a dropped m_req.
- FSM states IDLE, BUSY, RESP.
- IDLE: samples c_req and d_req.
  - Neither high: stay IDLE.
  - Exactly one high: grant it.
  - Both high: grant the port opposite to owner.
  - On grant: latch winner we/addr/wdata into the m_* registers, set owner = winner, clear counter, go to BUSY.
- BUSY:
  - m_req = 1; m_we, m_addr, m_wdata are stable for the whole state.
  - m_ack = 1: on a read, capture m_rdata into the winner's rdata register; go to RESP.
  - m_ack = 0: increment the counter. If counter == TIMEOUT-1 at the edge, set err = 1, load the winner's rdata with 0 on a read, and go to RESP.
- RESP:
  - m_req = 0; the winner's ack = 1 for exactly this cycle; next state IDLE.
  - Requests presented during RESP are not sampled.
  - A requester must show req low, or a new request, from the first cycle after its ack.
- Writes leave the rdata registers unchanged. rdata holds its value between acks.
- Latency: a req sampled in cycle 0 drives m_req in cycle 1. With zero-wait memory (m_ack in cycle 1), ack arrives in cycle 2. Minimum 3-cycle issue interval per transaction.
- c_stall = c_req & ~c_ack (combinational). It is high while the CPU waits, including while port D is being served.
- d_req is never stalled indefinitely: after any C grant, a pending D request wins the next tie. The symmetric rule applies for C.
- err clears only on rst. After a timeout the arbiter keeps operating normally.

Decomposition:
- Shared package/define file holds:
  - state encoding (IDLE=2'd0, BUSY=2'd1, RESP=2'd2)
  - port IDs PORT_C=1'b0, PORT_D=1'b1
  - reuse of `DSIZE from define.v
- One natural sub-module, rr_arb2: a combinational 2-way round-robin picker. Inputs req[1:0] and last owner; outputs grant valid and winner.
- FSM, counter and datapath registers stay in dmem_arbiter.

Test Plan:
- CPU read only: c_req=1, c_addr=16'h0004, memory returns 16'hBEEF with m_ack in the first BUSY cycle → m_req in cycle 1 with m_addr=4, c_ack in cycle 2 with c_rdata=16'hBEEF, c_stall high in cycles 0-1 and low in cycle 2.
- Simultaneous requests after reset: c_req and d_req both high → C granted first (owner=0); D granted on the next IDLE (owner=1); each ack pulses exactly once.
- Back-to-back contention: C and D both hold requests for 4 transactions → grant sequence C, D, C, D with no port served twice in a row.
- Debug write: d_we=1, d_addr=16'h0010, d_wdata=16'h1234 with 3 wait cycles before m_ack → m_we=1, m_addr=16'h0010, m_wdata=16'h1234 stable for 4 BUSY cycles, then d_ack; d_rdata unchanged.
- Timeout: c_req read, m_ack held 0 → after 15 BUSY cycles err=1, c_ack pulses with c_rdata=0; a following D read completes normally while err stays 1.
- Reset mid-BUSY: rst high for one cycle during a C read → next cycle m_req=0, c_ack=0, owner=1, state IDLE; a request re-issued after rst deasserts completes normally.
